// File: rtl/keycode_pack.sv
// Packs twelve synchronised game-button levels into a four-slot HID keycode word
// with stable slot assignment, error-rollover, and a valid/ready report handshake.
module keycode_pack #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [7:0]  ROLLOVER_CODE = 8'h01
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [11:0] buttons,
  output logic [31:0] keycode,
  output logic        report_valid,
  input  logic        report_ready
);

  localparam int unsigned NKEYS  = 12;
  localparam int unsigned NSLOTS = 4;
  localparam int unsigned IDXW   = 4;

  typedef enum logic {IDLE, PEND} state_t;

  function automatic logic [7:0] key_code(input logic [IDXW-1:0] idx);
    logic [7:0] c;
    c = 8'h00;
    case (idx)
      4'd0:  c = 8'h52;
      4'd1:  c = 8'h51;
      4'd2:  c = 8'h50;
      4'd3:  c = 8'h4F;
      4'd4:  c = 8'h38;
      4'd5:  c = 8'h15;
      4'd6:  c = 8'h28;
      4'd7:  c = 8'h1A;
      4'd8:  c = 8'h16;
      4'd9:  c = 8'h04;
      4'd10: c = 8'h07;
      4'd11: c = 8'h0A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [NKEYS-1:0] sync_q [SYNC_STAGES];
  logic [NKEYS-1:0] sb;

  logic [NSLOTS-1:0]           slot_used, slot_used_n;
  logic [NSLOTS-1:0][IDXW-1:0] slot_idx, slot_idx_n;
  logic                        overflow, overflow_n;
  logic [31:0]                 rpt_next;

  state_t      state, state_n;
  logic [31:0] keycode_n, last_sent, last_sent_n;
  logic        report_valid_n;

  // Button synchronisers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= buttons;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sb = sync_q[SYNC_STAGES-1];

  // Slot table update: release all freed slots, then allocate one new key
  always_comb begin
    logic [15:0]     present;
    logic            cand_ok;
    logic [IDXW-1:0] cand;
    logic            free_ok;
    logic [1:0]      free_slot;
    logic [3:0]      pop;

    slot_used_n = slot_used;
    slot_idx_n  = slot_idx;
    present     = '0;
    cand_ok     = 1'b0;
    cand        = '0;
    free_ok     = 1'b0;
    free_slot   = '0;
    pop         = '0;

    for (int k = 0; k < int'(NSLOTS); k++) begin
      if (slot_used[k] && !sb[slot_idx[k]]) slot_used_n[k] = 1'b0;
    end
    for (int k = 0; k < int'(NSLOTS); k++) begin
      if (slot_used_n[k]) present[slot_idx_n[k]] = 1'b1;
    end
    for (int i = 0; i < int'(NKEYS); i++) begin
      if (!cand_ok && sb[i] && !present[i]) begin
        cand_ok = 1'b1;
        cand    = IDXW'(i);
      end
      pop = pop + 4'(sb[i]);
    end
    for (int k = 0; k < int'(NSLOTS); k++) begin
      if (!free_ok && !slot_used_n[k]) begin
        free_ok   = 1'b1;
        free_slot = 2'(k);
      end
    end
    if (cand_ok && free_ok) begin
      slot_used_n[free_slot] = 1'b1;
      slot_idx_n[free_slot]  = cand;
    end
    overflow_n = (pop > 4'd4);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slot_used <= '0;
      slot_idx  <= '0;
      overflow  <= 1'b0;
    end else begin
      slot_used <= slot_used_n;
      slot_idx  <= slot_idx_n;
      overflow  <= overflow_n;
    end
  end

  // Report image from the registered slot table
  always_comb begin
    rpt_next = '0;
    if (overflow) begin
      rpt_next = {NSLOTS{ROLLOVER_CODE}};
    end else begin
      for (int k = 0; k < int'(NSLOTS); k++) begin
        rpt_next[8*k +: 8] = slot_used[k] ? key_code(slot_idx[k]) : 8'h00;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      keycode      <= '0;
      report_valid <= 1'b0;
      last_sent    <= '0;
    end else begin
      state        <= state_n;
      keycode      <= keycode_n;
      report_valid <= report_valid_n;
      last_sent    <= last_sent_n;
    end
  end

  // Handshake: the pending word stays frozen until accepted
  always_comb begin
    state_n        = state;
    keycode_n      = keycode;
    report_valid_n = report_valid;
    last_sent_n    = last_sent;
    case (state)
      IDLE: begin
        if (rpt_next != last_sent) begin
          keycode_n      = rpt_next;
          report_valid_n = 1'b1;
          state_n        = PEND;
        end
      end
      PEND: begin
        if (report_ready) begin
          last_sent_n    = keycode;
          report_valid_n = 1'b0;
          state_n        = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keycode_pack.sv
// Directed bench for keycode_pack: latency, slot reuse, rollover, back-pressure, async reset.
module tb_keycode_pack;

  logic        Clk;
  logic        Reset;
  logic [11:0] buttons;
  logic [31:0] keycode;
  logic        report_valid;
  logic        report_ready;

  int total = 0;
  int bad   = 0;

  keycode_pack dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .buttons      (buttons),
    .keycode      (keycode),
    .report_valid (report_valid),
    .report_ready (report_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Wait (bounded) for a report, check it, and check it is taken on the next edge
  task automatic wait_report(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!report_valid && n < 40);
    chk({tag, "_valid"}, 32'(report_valid), 32'h1);
    chk({tag, "_code"}, keycode, exp);
    cyc();
    chk({tag, "_acc"}, 32'(report_valid), 32'h0);
  endtask

  initial begin
    int n;
    Reset        = 1'b0;
    buttons      = '0;
    report_ready = 1'b1;
    #3 Reset = 1'b1;
    #1;
    chk("rst_code", keycode, 32'h0);
    chk("rst_valid", 32'(report_valid), 32'h0);
    repeat (2) cyc();
    Reset = 1'b0;

    // Idle with no buttons: nothing is ever reported
    repeat (10) cyc();
    chk("idle_valid", 32'(report_valid), 32'h0);
    chk("idle_code", keycode, 32'h0);

    // Latency: press up just after an edge, report_valid appears after the 4th edge
    buttons = 12'h001;
    for (int e = 1; e <= 3; e++) begin
      cyc();
      chk($sformatf("lat_e%0d", e), 32'(report_valid), 32'h0);
    end
    cyc();
    chk("lat_e4_valid", 32'(report_valid), 32'h1);
    chk("lat_e4_code", keycode, 32'h00000052);
    cyc();
    chk("lat_acc", 32'(report_valid), 32'h0);
    buttons = 12'h000;
    wait_report("up_rel", 32'h00000000);

    // Stable slots: right, + shoot2, release right, + Start reuses slot0
    buttons = 12'h008;
    wait_report("right", 32'h0000004F);
    buttons = 12'h808;
    wait_report("shoot2", 32'h00000A4F);
    buttons = 12'h800;
    wait_report("right_rel", 32'h00000A00);
    buttons = 12'h840;
    wait_report("start", 32'h00000A28);
    buttons = 12'h000;
    wait_report("all_rel", 32'h00000000);

    // Five held keys give error-rollover; dropping one exposes the slot contents
    buttons = 12'h01F;
    wait_report("roll", 32'h01010101);
    buttons = 12'h00F;
    wait_report("roll_rel", 32'h4F505152);

    // Back-pressure: the pending word stays frozen while inputs change
    report_ready = 1'b0;
    buttons = 12'h001;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!report_valid && n < 40);
    chk("bp_valid", 32'(report_valid), 32'h1);
    chk("bp_code", keycode, 32'h00000052);
    buttons = 12'h003;
    repeat (8) cyc();
    chk("bp_hold_valid", 32'(report_valid), 32'h1);
    chk("bp_hold_code", keycode, 32'h00000052);
    report_ready = 1'b1;
    cyc();
    chk("bp_one_acc", 32'(report_valid), 32'h0);
    wait_report("bp_next", 32'h00005152);

    // Reset while pending clears outputs at once; held keys are reported afterwards
    report_ready = 1'b0;
    buttons = 12'h040;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!report_valid && n < 40);
    chk("pend_code", keycode, 32'h00000028);
    #2 Reset = 1'b1;
    #1;
    chk("arst_code", keycode, 32'h0);
    chk("arst_valid", 32'(report_valid), 32'h0);
    repeat (2) cyc();
    Reset = 1'b0;
    report_ready = 1'b1;
    wait_report("post_rst", 32'h00000028);
    buttons = 12'h000;
    wait_report("final_rel", 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
